// File: rtl/mul_sched_pkg.sv
// Shared constants and helpers for the multiplier-sharing scheduler.
// Default widths match a 32x13 unsigned multiplier with a 44-bit product port.
package mul_sched_pkg;

    localparam int NREQ_MAX    = 8;
    localparam int LATENCY_MAX = 4;

    localparam int DEF_NREQ    = 4;
    localparam int DEF_A_W     = 32;
    localparam int DEF_B_W     = 13;
    localparam int DEF_P_W     = 44;
    localparam int DEF_LATENCY = 1;

    // A single requester still needs a one-bit id field.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mul_rr_pick.sv
// Combinational round-robin picker: starting after ptr_i, selects the first
// asserted request, wrapping modulo NREQ.
module mul_rr_pick
    import mul_sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int ID_W = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic [NREQ-1:0] grant_oh_o,
    output logic [ID_W-1:0] grant_idx_o,
    output logic            any_grant_o
);

    logic found;

    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return s[ID_W-1:0];
    endfunction

    // Scanning offsets 1..NREQ visits ptr+1 first and the last winner last.
    always_comb begin
        found       = 1'b0;
        grant_oh_o  = '0;
        grant_idx_o = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && req_i[wrap_idx(ptr_i, k)]) begin
                found                         = 1'b1;
                grant_idx_o                   = wrap_idx(ptr_i, k);
                grant_oh_o[wrap_idx(ptr_i, k)] = 1'b1;
            end
        end
        any_grant_o = found;
    end

endmodule

// File: rtl/mul_share_sched.sv
// Round-robin scheduler sharing one external pipelined multiplier between
// NREQ requesters; requester ids travel alongside the multiplier pipeline.
module mul_share_sched
    import mul_sched_pkg::*;
#(
    parameter int NREQ      = DEF_NREQ,
    parameter int A_W       = DEF_A_W,
    parameter int B_W       = DEF_B_W,
    parameter int P_W       = DEF_P_W,
    parameter int LATENCY   = DEF_LATENCY,
    localparam int ID_W     = id_width(NREQ)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*A_W-1:0] req_a,
    input  logic [NREQ*B_W-1:0] req_b,
    output logic              mul_ce,
    output logic [A_W-1:0]    mul_din0,
    output logic [B_W-1:0]    mul_din1,
    input  logic [P_W-1:0]    mul_dout,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [P_W-1:0]    res_data,
    output logic [ID_W-1:0]   res_id
);

    if (P_W != A_W + B_W - 1) begin : g_bad_pw
        $error("mul_share_sched: P_W must equal A_W+B_W-1");
    end
    if (NREQ < 2 || NREQ > NREQ_MAX) begin : g_bad_nreq
        $error("mul_share_sched: NREQ out of range 2..8");
    end
    if (LATENCY < 1 || LATENCY > LATENCY_MAX) begin : g_bad_lat
        $error("mul_share_sched: LATENCY out of range 1..4");
    end

    logic              stall;
    logic              xfer;
    logic [NREQ-1:0]   grant_oh;
    logic [ID_W-1:0]   grant_idx;
    logic              any_grant;

    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [LATENCY-1:0] vld_q, vld_d;
    logic [ID_W-1:0]    id_q [LATENCY];
    logic [ID_W-1:0]    id_d [LATENCY];

    mul_rr_pick #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_pick (
        .req_i       (req_valid),
        .ptr_i       (ptr_q),
        .grant_oh_o  (grant_oh),
        .grant_idx_o (grant_idx),
        .any_grant_o (any_grant)
    );

    // A held result freezes the whole pipe; grants are also blocked in reset.
    assign stall     = res_valid & ~res_ready;
    assign mul_ce    = ~stall;
    assign xfer      = any_grant & ~stall & ~reset;
    assign req_ready = xfer ? grant_oh : '0;

    always_comb begin
        mul_din0 = '0;
        mul_din1 = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (xfer && grant_oh[i]) begin
                mul_din0 = req_a[i*A_W +: A_W];
                mul_din1 = req_b[i*B_W +: B_W];
            end
        end
    end

    assign ptr_d = xfer ? grant_idx : ptr_q;

    always_comb begin
        vld_d = vld_q;
        id_d  = id_q;
        if (mul_ce) begin
            vld_d[0] = xfer;
            id_d[0]  = xfer ? grant_idx : '0;
            for (int s = 1; s < LATENCY; s++) begin
                vld_d[s] = vld_q[s-1];
                id_d[s]  = id_q[s-1];
            end
        end
    end

    // Pointer resets to the last index so the first scan starts at requester 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= ID_W'(NREQ - 1);
            vld_q <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                id_q[s] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            vld_q <= vld_d;
            id_q  <= id_d;
        end
    end

    assign res_valid = vld_q[LATENCY-1];
    assign res_id    = id_q[LATENCY-1];
    assign res_data  = mul_dout;

endmodule

// File: tb/tb_mul_share_sched.sv
// Directed scoreboard bench for mul_share_sched with a behavioural
// clock-enabled multiplier standing in for the external instance.
module tb_mul_share_sched;

    localparam int NREQ = 4;
    localparam int A_W  = 32;
    localparam int B_W  = 13;
    localparam int P_W  = 44;
    localparam int LAT  = 2;
    localparam int ID_W = 2;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [P_W-1:0]  data;
    } exp_t;

    logic                clk;
    logic                reset;
    logic [NREQ-1:0]     reqValid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*A_W-1:0] reqA;
    logic [NREQ*B_W-1:0] reqB;
    logic                mul_ce;
    logic [A_W-1:0]      mul_din0;
    logic [B_W-1:0]      mul_din1;
    logic [P_W-1:0]      mul_dout;
    logic                res_valid;
    logic                resReady;
    logic [P_W-1:0]      res_data;
    logic [ID_W-1:0]     res_id;

    logic [P_W-1:0]      mulPipe [LAT];

    int                  nCmp;
    int                  nFail;
    int                  mdlPtr;
    logic [LAT-1:0]      mdlVld;
    exp_t                expQ [$];

    mul_share_sched #(
        .NREQ    (NREQ),
        .A_W     (A_W),
        .B_W     (B_W),
        .P_W     (P_W),
        .LATENCY (LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (reqValid),
        .req_ready (req_ready),
        .req_a     (reqA),
        .req_b     (reqB),
        .mul_ce    (mul_ce),
        .mul_din0  (mul_din0),
        .mul_din1  (mul_din1),
        .mul_dout  (mul_dout),
        .res_valid (res_valid),
        .res_ready (resReady),
        .res_data  (res_data),
        .res_id    (res_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // The external multiplier truncates to its P_W-bit dout port.
    always @(posedge clk) begin
        if (mul_ce) begin
            mulPipe[0] <= P_W'(64'(mul_din0) * 64'(mul_din1));
            for (int s = 1; s < LAT; s++) begin
                mulPipe[s] <= mulPipe[s-1];
            end
        end
    end
    assign mul_dout = mulPipe[LAT-1];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nCmp++;
        assert (got === exp) else begin
            nFail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic rdy);
        reqValid = valid;
        resReady = rdy;
    endtask

    task automatic setOperand(input int i, input logic [A_W-1:0] a, input logic [B_W-1:0] b);
        reqA[i*A_W +: A_W] = a;
        reqB[i*B_W +: B_W] = b;
    endtask

    task automatic randomOperands();
        for (int i = 0; i < NREQ; i++) begin
            setOperand(i, A_W'($urandom), B_W'($urandom));
        end
    endtask

    task automatic modelReset();
        expQ.delete();
        mdlVld = '0;
        mdlPtr = NREQ - 1;
    endtask

    // Checks one cycle at the falling edge, then advances the model at the rising edge.
    task automatic checkOutput();
        logic [NREQ-1:0] expReady;
        logic            resV;
        logic            stallM;
        int              gidx;
        exp_t            e;
        logic [63:0]     prod;
        @(negedge clk);
        resV     = mdlVld[LAT-1];
        stallM   = resV && !resReady;
        expReady = '0;
        gidx     = -1;
        if (!stallM) begin
            for (int k = 1; k <= NREQ; k++) begin
                if (gidx < 0 && reqValid[(mdlPtr + k) % NREQ]) begin
                    gidx = (mdlPtr + k) % NREQ;
                end
            end
        end
        if (gidx >= 0) expReady[gidx] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(expReady));
        check("mul_ce", 64'(mul_ce), 64'(!stallM));
        check("res_valid", 64'(res_valid), 64'(resV));
        if (resV) begin
            if (expQ.size() == 0) begin
                nCmp++;
                nFail++;
                $error("[TB] FAIL scoreboard: observed result expected none");
            end else begin
                check("res_data", 64'(res_data), 64'(expQ[0].data));
                check("res_id", 64'(res_id), 64'(expQ[0].id));
            end
        end
        if (gidx >= 0) begin
            check("mul_din0", 64'(mul_din0), 64'(reqA[gidx*A_W +: A_W]));
            check("mul_din1", 64'(mul_din1), 64'(reqB[gidx*B_W +: B_W]));
        end
        @(posedge clk);
        if (resV && resReady) void'(expQ.pop_front());
        if (!stallM) begin
            for (int s = LAT - 1; s > 0; s--) begin
                mdlVld[s] = mdlVld[s-1];
            end
            mdlVld[0] = (gidx >= 0);
            if (gidx >= 0) begin
                prod   = 64'(reqA[gidx*A_W +: A_W]) * 64'(reqB[gidx*B_W +: B_W]);
                e.id   = ID_W'(gidx);
                e.data = prod[P_W-1:0];
                expQ.push_back(e);
                mdlPtr = gidx;
            end
        end
        #1;
    endtask

    initial begin
        nCmp     = 0;
        nFail    = 0;
        reset    = 1'b1;
        reqValid = '0;
        resReady = 1'b1;
        reqA     = '0;
        reqB     = '0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        reqValid = 4'b0101;
        #1;
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_res_valid", 64'(res_valid), 64'(0));
        check("rst_res_id", 64'(res_id), 64'(0));
        check("rst_mul_ce", 64'(mul_ce), 64'(1));
        reqValid = '0;
        reset    = 1'b0;

        // Single request, 7*3 from requester 0.
        setOperand(0, 32'd7, 13'd3);
        applyStimulus(4'b0001, 1'b1);
        checkOutput();
        applyStimulus(4'b0000, 1'b1);
        repeat (LAT + 1) checkOutput();

        // Everyone valid: rotating grants, one result per cycle.
        applyStimulus(4'b1111, 1'b1);
        for (int c = 0; c < 8; c++) begin
            randomOperands();
            checkOutput();
        end

        // Consumer back-pressure while all requesters keep asking.
        applyStimulus(4'b1111, 1'b0);
        repeat (3) checkOutput();
        applyStimulus(4'b1111, 1'b1);
        repeat (4) checkOutput();
        applyStimulus(4'b0000, 1'b1);
        repeat (LAT + 1) checkOutput();
        check("drain_empty", 64'(expQ.size()), 64'(0));

        // Maximum operands from a lone requester, granted every cycle.
        setOperand(2, 32'hFFFF_FFFF, 13'h1FFF);
        applyStimulus(4'b0100, 1'b1);
        repeat (3) checkOutput();
        applyStimulus(4'b0000, 1'b1);
        repeat (LAT + 1) checkOutput();

        // Requesters 1 and 3 alternate once the pointer sits on 1.
        randomOperands();
        applyStimulus(4'b0010, 1'b1);
        checkOutput();
        applyStimulus(4'b1010, 1'b1);
        repeat (3) checkOutput();
        applyStimulus(4'b0000, 1'b1);
        repeat (LAT + 1) checkOutput();

        // Asynchronous reset with results in flight.
        applyStimulus(4'b0001, 1'b1);
        checkOutput();
        applyStimulus(4'b0010, 1'b1);
        checkOutput();
        resReady = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("arst_res_valid", 64'(res_valid), 64'(0));
        check("arst_req_ready", 64'(req_ready), 64'(0));
        check("arst_res_id", 64'(res_id), 64'(0));
        check("arst_mul_ce", 64'(mul_ce), 64'(1));
        modelReset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(4'b0110, 1'b1);
        checkOutput();
        applyStimulus(4'b0100, 1'b1);
        checkOutput();
        applyStimulus(4'b0000, 1'b1);
        repeat (LAT + 2) checkOutput();
        check("final_empty", 64'(expQ.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
